// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO with programmable almost-full/empty
// thresholds, sticky overflow/underflow flags and a choice of registered
// or first-word-fall-through read data.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   wr_en, din            write request and data (ignored while full)
//   rd_en                 read request / pop (ignored while empty)
//   err_clr               clears overflow/underflow (a same-cycle set wins)
//   dout                  read data
//   full, empty           occupancy flags derived from count
//   almost_full           count >= AF_THRESH
//   almost_empty          count <= AE_THRESH
//   count                 entries stored, 0..DEPTH
//   overflow, underflow   sticky rejected-write / rejected-read flags
module sync_fifo_prog #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd_en,
  input  logic                     err_clr,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             wr_ok, rd_ok;

  // Flags come straight off the registered count, so they track it with
  // no additional latency.
  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_THRESH));
  assign almost_empty = (count <= CW'(AE_THRESH));

  // When full, a simultaneous read is still accepted and the write is
  // rejected; when empty, the write is accepted and the read rejected.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  // Storage needs no reset; stale entries are unreachable once pointers
  // and count are cleared.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= din;
  end

  // Pointer width is exactly log2(DEPTH), so natural rollover is modulo DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags: a set event outranks err_clr in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full)  overflow <= 1'b1;
      else if (err_clr)   overflow <= 1'b0;
      if (rd_en && empty) underflow <= 1'b1;
      else if (err_clr)   underflow <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word presented combinationally; forced to 0 while empty so the
      // post-reset value is defined even though it is don't-care.
      assign dout = empty ? '0 : mem[rd_ptr];
    end else begin : g_std
      logic [WIDTH-1:0] dout_q;
      // Registered read: loads only on an accepted read, holds otherwise.
      always_ff @(posedge clk) begin
        if (!rst_n)     dout_q <= '0;
        else if (rd_ok) dout_q <= mem[rd_ptr];
      end
      assign dout = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_prog.sv
module tb_sync_fifo_prog;

  logic       clk = 1'b0;
  logic       rst_n, wr_en, rd_en, err_clr;
  logic [7:0] din;

  // Standard-read instance
  logic [7:0] dout0;
  logic       full0, empty0, af0, ae0, ovf0, udf0;
  logic [3:0] count0;
  // FWFT instance, same stimulus
  logic [7:0] dout1;
  logic       full1, empty1, af1, ae1, ovf1, udf1;
  logic [3:0] count1;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  sync_fifo_prog #(.WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din), .rd_en(rd_en), .err_clr(err_clr),
    .dout(dout0), .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(count0), .overflow(ovf0), .underflow(udf0));

  sync_fifo_prog #(.WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din), .rd_en(rd_en), .err_clr(err_clr),
    .dout(dout1), .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .count(count1), .overflow(ovf1), .underflow(udf1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic w, input logic [7:0] d, input logic r,
                      input logic c = 1'b0, input logic rs = 1'b1);
    wr_en = w; din = d; rd_en = r; err_clr = c; rst_n = rs;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] e;
    int nw, nr, cyc;
    logic w, r, wa, ra;

    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; din = 8'h00;

    // Reset, with a write request that must be overridden
    step(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
    chk("rst_count", count0, 0);
    chk("rst_empty", empty0, 1);
    chk("rst_ae",    ae0, 1);
    chk("rst_full",  full0, 0);
    chk("rst_af",    af0, 0);
    chk("rst_dout",  dout0, 0);
    chk("rst_ovf",   ovf0, 0);
    chk("rst_udf",   udf0, 0);

    // Fill 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 8'(i), 1'b0);
      chk("fill_count", count0, i);
      chk("fill_ae",    ae0, (i <= 2));
      chk("fill_af",    af0, (i >= 6));
      chk("fill_full",  full0, (i == 8));
    end
    step(1'b1, 8'h09, 1'b0);
    chk("wr9_ovf",   ovf0, 1);
    chk("wr9_count", count0, 8);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_ovf", ovf0, 0);

    // Drain; registered data appears one cycle after rd_en
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 8'h00, 1'b1);
      chk("drain_dout",  dout0, i);
      chk("drain_count", count0, 8 - i);
    end
    chk("drain_empty", empty0, 1);
    step(1'b0, 8'h00, 1'b1);
    chk("rd9_udf",  udf0, 1);
    chk("rd9_dout", dout0, 8'h08);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_udf", udf0, 0);

    // Simultaneous read/write at count 3
    step(1'b1, 8'h10, 1'b0);
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h12, 1'b0);
    step(1'b1, 8'h13, 1'b1);
    chk("rw3_count", count0, 3);
    chk("rw3_dout",  dout0, 8'h10);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b1);
      chk("rw3_order", dout0, 8'h11 + i);
    end

    // Simultaneous at empty: write wins, read flagged
    step(1'b1, 8'h20, 1'b1);
    chk("rwE_count", count0, 1);
    chk("rwE_udf",   udf0, 1);
    chk("rwE_dout",  dout0, 8'h13);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 1; i < 8; i++) step(1'b1, 8'h20 + 8'(i), 1'b0);
    chk("rwF_pre_full", full0, 1);
    // Simultaneous at full: read wins, write flagged
    step(1'b1, 8'h99, 1'b1);
    chk("rwF_count", count0, 7);
    chk("rwF_ovf",   ovf0, 1);
    chk("rwF_dout",  dout0, 8'h20);

    // Randomly interleaved stream of 20 words across pointer wrap
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    nw = 0; nr = 0; cyc = 0;
    while (nr < 20 && cyc < 1000) begin
      w  = (nw < 20) && ($urandom_range(0, 1) == 1);
      r  = ($urandom_range(0, 2) != 0);
      wa = w && (q.size() < 8);
      ra = r && (q.size() > 0);
      e  = 8'h00;
      if (ra) e = q.pop_front();
      step(w, 8'(nw), r);
      if (wa) begin q.push_back(8'(nw)); nw++; end
      if (ra) begin chk("stream_dout", dout0, e); nr++; end
      chk("stream_count", count0, q.size());
      cyc++;
    end
    chk("stream_done", nr, 20);

    // Reset mid-operation at count 5 with overflow set
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
    chk("mid_pre_count", count0, 5);
    chk("mid_pre_ovf",   ovf0, 1);
    step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    chk("mid_count", count0, 0);
    chk("mid_empty", empty0, 1);
    chk("mid_ovf",   ovf0, 0);
    chk("mid_dout",  dout0, 0);
    step(1'b1, 8'h55, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    chk("mid_first", dout0, 8'h55);

    // First-word-fall-through instance
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("fwft_rst_empty", empty1, 1);
    step(1'b1, 8'hAA, 1'b0);
    chk("fwft_empty", empty1, 0);
    chk("fwft_dout",  dout1, 8'hAA);
    step(1'b0, 8'h00, 1'b0);
    chk("fwft_hold",  dout1, 8'hAA);
    step(1'b0, 8'h00, 1'b1);
    chk("fwft_pop_empty", empty1, 1);
    chk("fwft_pop_count", count1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
